// File: rtl/regbank8_writer_if.sv
// Write-request channel of the 8-entry register bank: valid/ready handshake
// carrying a 3-bit destination index and WIDTH-bit data.
interface regbank8_writer_if #(
  parameter int unsigned WIDTH = 64
);
  logic             wr_valid;
  logic             wr_ready;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/regbank8_writer.sv
// Write side of the 8-entry register bank: a small request FIFO drained one
// entry per cycle through a 3:8 one-hot enable decoder into eight registers,
// plus a per-register scoreboard of writes still queued.
module regbank8_writer #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 2,
  parameter bit          ZERO_REG7 = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regbank8_writer_if.slave      wr,
  input  logic                  hold,
  output logic [7:0][WIDTH-1:0] regs_out,
  output logic [7:0]            busy,
  output logic [2:0]            fifo_count
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  DEPTH_C = 3'(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

  logic [2:0]       addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [2:0]       count_q;

  logic             push;
  logic             pop;
  logic [2:0]       head_addr;
  logic [WIDTH-1:0] head_data;
  logic [7:0]       we;
  logic [7:0]       busy_c;

  logic [7:0][WIDTH-1:0] regs_q;

  // Ready depends on the registered count only, never on valid or hold.
  assign wr.wr_ready = (count_q != DEPTH_C);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = (count_q != 3'd0) && !hold;
  assign head_addr   = addr_q[rd_ptr];
  assign head_data   = data_q[rd_ptr];
  assign fifo_count  = count_q;

  // FIFO pointers and occupancy; count alone separates full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO payload storage; contents are only meaningful while occupied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        addr_q[j] <= '0;
        data_q[j] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr] <= wr.wr_addr;
      data_q[wr_ptr] <= wr.wr_data;
    end
  end

  // One-hot commit enable for the head address; register 7 may be masked off.
  always_comb begin
    we = '0;
    if (pop) we[head_addr] = 1'b1;
    if (ZERO_REG7) we[7] = 1'b0;
  end

  // Register file: only the enabled register loads the head data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (we[i]) regs_q[i] <= head_data;
      end
    end
  end

  // Scoreboard: an entry is occupied when its distance from the read pointer
  // (modulo DEPTH) is below the count.
  always_comb begin
    busy_c = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      int unsigned off;
      off = (j >= int'(rd_ptr)) ? j - int'(rd_ptr) : j + DEPTH - int'(rd_ptr);
      if (off < int'(count_q)) busy_c[addr_q[j]] = 1'b1;
    end
    if (ZERO_REG7) busy_c[7] = 1'b0;
  end

  // Output bus; register 7 reads as zero when hardwired.
  always_comb begin
    regs_out = regs_q;
    if (ZERO_REG7) regs_out[7] = '0;
  end

  assign busy = busy_c;

endmodule

// File: tb/tb_regbank8_writer.sv
// Directed table-driven bench for regbank8_writer (WIDTH=64, DEPTH=2,
// ZERO_REG7=1) with hand-written reset sequences.
module tb_regbank8_writer;

  logic                clk;
  logic                reset_n;
  logic                hold;
  logic [7:0][63:0]    regs_out;
  logic [7:0]          busy;
  logic [2:0]          fifo_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  regbank8_writer_if #(.WIDTH(64)) wr_if ();

  regbank8_writer #(
    .WIDTH     (64),
    .DEPTH     (2),
    .ZERO_REG7 (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr         (wr_if.slave),
    .hold       (hold),
    .regs_out   (regs_out),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  addr;
    logic [63:0] data;
    logic        hold;
    logic [2:0]  exp_count;
    logic [7:0]  exp_busy;
    logic        exp_ready;
    logic [2:0]  chk_idx;
    logic [63:0] exp_reg;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic v, input logic [2:0] a, input logic [63:0] d,
                         input logic h, input logic [2:0] c, input logic [7:0] b,
                         input logic r, input logic [2:0] idx, input logic [63:0] e);
    vec_t x;
    x.valid = v; x.addr = a; x.data = d; x.hold = h;
    x.exp_count = c; x.exp_busy = b; x.exp_ready = r;
    x.chk_idx = idx; x.exp_reg = e;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic [63:0] d, input logic h);
    wr_if.wr_valid = v;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    hold           = h;
  endtask

  logic [63:0] final_regs [8];

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 3'd1, 64'hFF, 1'b0);

    // Requests while in reset are ignored; outputs at reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(wr_if.wr_ready), 64'd1);
    for (int i = 0; i < 8; i++) check($sformatf("rst_reg%0d", i), regs_out[i], 64'd0);

    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 1'b0);
    reset_n = 1'b1;

    // Single write to reg 3: busy for one cycle, visible after the next edge.
    add_vec(1, 3'd3, 64'h1122334455667788, 0, 3'd1, 8'h08, 1, 3'd3, 64'h0);
    add_vec(0, 3'd0, 64'h0,                0, 3'd0, 8'h00, 1, 3'd3, 64'h1122334455667788);
    // Held FIFO fills, then drains in order.
    add_vec(1, 3'd0, 64'hA, 1, 3'd1, 8'h01, 1, 3'd0, 64'h0);
    add_vec(1, 3'd1, 64'hB, 1, 3'd2, 8'h03, 0, 3'd0, 64'h0);
    add_vec(0, 3'd0, 64'h0, 0, 3'd1, 8'h02, 1, 3'd0, 64'hA);
    add_vec(0, 3'd0, 64'h0, 0, 3'd0, 8'h00, 1, 3'd1, 64'hB);
    // Two queued writes to reg 5: later data wins, busy held until the last.
    add_vec(1, 3'd5, 64'h1, 1, 3'd1, 8'h20, 1, 3'd5, 64'h0);
    add_vec(1, 3'd5, 64'h2, 1, 3'd2, 8'h20, 0, 3'd5, 64'h0);
    add_vec(0, 3'd0, 64'h0, 0, 3'd1, 8'h20, 1, 3'd5, 64'h1);
    add_vec(0, 3'd0, 64'h0, 0, 3'd0, 8'h00, 1, 3'd5, 64'h2);
    // Address 7 is hardwired zero: accepted, never busy, never written.
    add_vec(1, 3'd7, '1,    0, 3'd1, 8'h00, 1, 3'd7, 64'h0);
    add_vec(0, 3'd0, 64'h0, 0, 3'd0, 8'h00, 1, 3'd7, 64'h0);
    // Back-to-back pushes with hold low: occupancy stays at 1.
    add_vec(1, 3'd0, 64'h100, 0, 3'd1, 8'h01, 1, 3'd0, 64'hA);
    add_vec(1, 3'd1, 64'h101, 0, 3'd1, 8'h02, 1, 3'd0, 64'h100);
    add_vec(1, 3'd2, 64'h102, 0, 3'd1, 8'h04, 1, 3'd1, 64'h101);
    add_vec(1, 3'd3, 64'h103, 0, 3'd1, 8'h08, 1, 3'd2, 64'h102);
    add_vec(1, 3'd4, 64'h104, 0, 3'd1, 8'h10, 1, 3'd3, 64'h103);
    add_vec(1, 3'd5, 64'h105, 0, 3'd1, 8'h20, 1, 3'd4, 64'h104);
    add_vec(1, 3'd6, 64'h106, 0, 3'd1, 8'h40, 1, 3'd5, 64'h105);
    add_vec(0, 3'd0, 64'h0,   0, 3'd0, 8'h00, 1, 3'd6, 64'h106);
    // Full FIFO with a pop: no push that edge; request retried next cycle.
    add_vec(1, 3'd2, 64'hD0D0, 1, 3'd1, 8'h04, 1, 3'd2, 64'h102);
    add_vec(1, 3'd4, 64'hD1D1, 1, 3'd2, 8'h14, 0, 3'd4, 64'h104);
    add_vec(1, 3'd6, 64'hD2D2, 0, 3'd1, 8'h10, 1, 3'd2, 64'hD0D0);
    add_vec(1, 3'd6, 64'hD2D2, 0, 3'd1, 8'h40, 1, 3'd4, 64'hD1D1);
    add_vec(0, 3'd0, 64'h0,    0, 3'd0, 8'h00, 1, 3'd6, 64'hD2D2);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].valid, vecs[k].addr, vecs[k].data, vecs[k].hold);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", k), 64'(fifo_count), 64'(vecs[k].exp_count));
      check($sformatf("v%0d_busy", k), 64'(busy), 64'(vecs[k].exp_busy));
      check($sformatf("v%0d_ready", k), 64'(wr_if.wr_ready), 64'(vecs[k].exp_ready));
      check($sformatf("v%0d_reg%0d", k, vecs[k].chk_idx), regs_out[vecs[k].chk_idx], vecs[k].exp_reg);
    end

    final_regs[0] = 64'h100;  final_regs[1] = 64'h101;
    final_regs[2] = 64'hD0D0; final_regs[3] = 64'h103;
    final_regs[4] = 64'hD1D1; final_regs[5] = 64'h105;
    final_regs[6] = 64'hD2D2; final_regs[7] = 64'h0;
    for (int i = 0; i < 8; i++) check($sformatf("final_reg%0d", i), regs_out[i], final_regs[i]);

    // Fill the FIFO, then reset asynchronously mid-cycle.
    @(negedge clk);
    drive(1'b1, 3'd1, 64'hEE, 1'b1);
    @(negedge clk);
    drive(1'b1, 3'd3, 64'hFF, 1'b1);
    @(posedge clk);
    #1;
    check("fill_count", 64'(fifo_count), 64'd2);
    check("fill_busy", 64'(busy), 64'h0A);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", 64'(fifo_count), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(wr_if.wr_ready), 64'd1);
    for (int i = 0; i < 8; i++) check($sformatf("arst_reg%0d", i), regs_out[i], 64'd0);

    @(negedge clk);
    drive(1'b0, 3'd0, 64'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_count", 64'(fifo_count), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
    check("post_reg1", regs_out[1], 64'd0);
    check("post_reg3", regs_out[3], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank8_writer.md
Name: regbank8_writer

Overview:
- Write side of the 8-entry, WIDTH-bit register bank whose read side is the 8:1 word selector.
- Accepts write requests (3-bit address, data) over a valid/ready handshake into a small FIFO.
- Commits one entry per cycle through a 3:8 one-hot write-enable decoder into eight WIDTH-bit registers.
- Exposes all eight registers as a packed [7:0][WIDTH-1:0] bus that feeds the selector directly, plus a per-register pending-write scoreboard.

Parameters:
- WIDTH, 64, data width of each register.
- DEPTH, 2, write FIFO depth in entries; legal range 1..4.
- ZERO_REG7, 1, when 1, register 7 is hardwired to zero.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  FIFO can accept a request this cycle.
- wr_addr  input  3  destination register index.
- wr_data  input  WIDTH  write data.
- hold  input  1  when 1, the FIFO head is not committed this cycle.
- regs_out  output  [7:0][WIDTH-1:0]  current register contents.
- busy  output  8  bit i = 1 while any FIFO entry targets register i.
- fifo_count  output  3  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: reset_n low asynchronously clears all registers, FIFO pointers and count.
  - While reset_n is low: regs_out = 0, busy = 0, fifo_count = 0, wr_ready = 1.
  - Requests presented while reset_n is low are ignored.
  - A reset mid-operation drops all pending writes; nothing is partially committed.
- Handshake:
  - wr_ready = (fifo_count != DEPTH), a function of registered count only; it has no combinational path from wr_valid or hold.
  - A push occurs at an edge where wr_valid && wr_ready.
  - The requester holds wr_addr/wr_data stable while wr_valid && !wr_ready.
- Commit: at each edge where fifo_count != 0 && !hold, pop the head and assert the decoded enable for head address.
  - Exactly one of the 8 enables is active, or none.
  - The selected register loads the head data; the other seven are unchanged.
- Latency:
  - A request accepted at edge N, with an empty FIFO and hold low, is visible on regs_out after edge N+1.
  - There is no same-cycle write-through from wr_data to regs_out.
- Simultaneous push and pop: allowed whenever wr_ready = 1; count is unchanged.
  - When count == DEPTH, no push occurs even if a pop occurs that edge, because ready was low.
- Count update rules:
  - Push only: count+1.
  - Pop only: count-1.
  - Both or neither: unchanged.
- Pointer wrap: read and write pointers wrap modulo DEPTH; count alone distinguishes full from empty.
- Ordering: writes commit in acceptance order. Two queued writes to the same address leave the later data in the register.
- busy[i] = OR over occupied entries of (entry.addr == i). It updates on the same edges as push and pop.
- ZERO_REG7 = 1:
  - Writes to address 7 are accepted and occupy a FIFO slot.
  - Their commit enables nothing.
  - regs_out[7] is always 0 and busy[7] is always 0.
- ZERO_REG7 = 0: register 7 behaves like registers 0..6.
- hold low with an empty FIFO: no register changes.

Test Plan:
- Reset, then write addr 3 data 0x1122334455667788 with hold=0 -> regs_out[3] equals the data one edge after acceptance; other registers stay 0; busy[3] is 1 for exactly one cycle.
- hold=1, push addr 0 = 0xA then addr 1 = 0xB -> fifo_count=2, wr_ready=0, busy=8'b00000011. Then release hold -> regs 0 and 1 update on consecutive edges; wr_ready returns to 1 after the first pop.
- hold=1, push addr 5 = 0x1 then addr 5 = 0x2; release -> busy[5] stays 1 until the second commit; final regs_out[5] = 0x2.
- Write all ones to addr 7 with ZERO_REG7=1 -> accepted (count goes 1 then 0); regs_out[7] remains 0; busy[7] never asserts.
- Continuous pushes every cycle to addrs 0..6 with hold=0 -> fifo_count never exceeds 1; all seven registers hold their data in acceptance order.
- Fill the FIFO to DEPTH, then pulse reset_n low mid-cycle -> regs_out, busy and fifo_count go to 0 immediately, without waiting for an edge; no queued write commits after reset release.
